mux8_rr_arbiter: RTL

Round-robin arbiter and sequencer that shares one 8:1 data mux among eight requesters. Each cycle it decides which lane owns the mux, drives the 3-bit select and a one-hot grant, and registers the selected lane's data onto a single output bus. A per-grant hold limit bounds ownership so no lane can starve the others. Sits between the eight lane sources and the single downstream consumer of the muxed bus.

---
 rtl/mux8_rr_arbiter_pkg.sv | 20 ++
 rtl/mux8_rr_arbiter_rr_pick8.sv | 38 +++
 rtl/mux8_rr_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mux8_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter_pkg
// Shared definitions for the 8-lane round-robin mux arbiter: lane count,
// select width, FSM state encoding and a one-hot decode helper.
// ---------------------------------------------------------------------------
package mux8_rr_arbiter_pkg;

  localparam int N_LANES = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [N_LANES-1:0] onehot(input logic [SEL_W-1:0] i);
    return N_LANES'(1) << i;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// ---------------------------------------------------------------------------
// rr_pick8
// Combinational circular priority picker. Scans req starting at ptr and
// wrapping (ptr, ptr+1, ..., ptr+7 mod 8); reports the first active lane.
//
// Ports:
//   req   in  8  per-lane request
//   ptr   in  3  highest-priority lane for this scan
//   found out 1  at least one request is active
//   idx   out 3  first active lane at or after ptr (ptr when none found)
// ---------------------------------------------------------------------------
module rr_pick8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N_LANES-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest active lane is the
  // last assignment and therefore wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = N_LANES - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
// Round-robin arbiter sharing one 8:1 data mux among eight lanes. Grants
// one lane at a time for at most MAX_HOLD consecutive cycles, drives the
// registered select and one-hot grant, and registers the selected lane's
// data onto dout.
//
// State table:
//   state    | meaning
//   ST_IDLE  | no lane owns the mux; scan from ptr each cycle
//   ST_GRANT | lane sel owns the mux; hold_cnt counts owned cycles
//
// Ports:
//   clk        in  1      clock, rising edge
//   rst_n      in  1      async active-low reset
//   req        in  8      per-lane request (level)
//   din        in  8*W    lane data, lane i at din[i*W +: W]
//   gnt        out 8      registered one-hot grant, zero when idle
//   sel        out 3      registered granted lane, holds when idle
//   busy       out 1      high while in ST_GRANT
//   dout       out W      registered muxed data
//   dout_valid out 1      dout carries a valid beat
// ---------------------------------------------------------------------------
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4    // legal range 1..15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_LANES-1:0]   req,
  input  logic [N_LANES*W-1:0] din,
  output logic [N_LANES-1:0]   gnt,
  output logic [SEL_W-1:0]     sel,
  output logic                 busy,
  output logic [W-1:0]         dout,
  output logic                 dout_valid
);

  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [3:0]       hold_cnt;

  logic [W-1:0]     lane [N_LANES];
  logic [SEL_W-1:0] sel_inc;
  logic [SEL_W-1:0] pick_ptr;
  logic             req_cur;
  logic             release_now;
  logic             found;
  logic [SEL_W-1:0] idx;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    assign lane[g] = din[g*W +: W];
  end

  assign sel_inc     = sel + SEL_W'(1);
  assign req_cur     = req[sel];
  assign release_now = !req_cur || (hold_cnt == HOLD_LIM);
  assign busy        = (state == ST_GRANT);

  // On release the lane just served drops to lowest priority, so the
  // re-pick in the same cycle scans from sel+1 rather than from ptr.
  assign pick_ptr = (state == ST_GRANT) ? sel_inc : ptr;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (found),
    .idx   (idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      hold_cnt   <= '0;
      gnt        <= '0;
      sel        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      // A lane that drops req while granted yields no beat that cycle.
      dout_valid <= busy & req_cur;
      if (busy & req_cur) begin
        dout <= lane[sel];
      end

      case (state)
        ST_IDLE: begin
          if (found) begin
            state    <= ST_GRANT;
            sel      <= idx;
            gnt      <= onehot(idx);
            hold_cnt <= 4'd1;
          end
        end
        ST_GRANT: begin
          if (!release_now) begin
            hold_cnt <= hold_cnt + 4'd1;
          end else begin
            ptr <= sel_inc;
            if (found) begin
              sel      <= idx;
              gnt      <= onehot(idx);
              hold_cnt <= 4'd1;
            end else begin
              state    <= ST_IDLE;
              gnt      <= '0;
              hold_cnt <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule
